// File: rtl/hazard3_ahbl_arbiter_pkg.sv
// Shared AHB-Lite encodings and arbitration mode values for the Hazard3 bus blocks.
package hazard3_ahbl_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NSEQ   = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam int unsigned ARB_FIXED    = 0;
  localparam int unsigned ARB_RR       = 1;

endpackage

// File: rtl/hazard3_arb_rr.sv
// Request-to-one-hot picker. With rotation enabled the search starts at ptr_i and
// wraps; otherwise the lowest requesting index wins.
module hazard3_arb_rr #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned W_PTR = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [W_PTR-1:0] ptr_i,
  input  logic             rr_en_i,
  output logic [N_REQ-1:0] gnt_o
);

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] sel;

  // Requests at or above the pointer take precedence; if none, fall back to the
  // full vector, which gives the wrap-around. Isolate the lowest set bit.
  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      mask[i] = (i >= int'(ptr_i));
    end
    masked = req_i & mask;
    sel    = (rr_en_i && (|masked)) ? masked : req_i;
    gnt_o  = sel & (~sel + N_REQ'(1));
  end

endmodule

// File: rtl/hazard3_ahbl_arbiter.sv
// N-port AHB-Lite arbiter: several upstream masters share one downstream master port.
// Each upstream port has a one-entry address-phase buffer so a request that loses
// arbitration (or is stalled downstream) is accepted upstream and replayed later.
module hazard3_ahbl_arbiter
  import hazard3_ahbl_arbiter_pkg::*;
#(
  parameter int unsigned N_PORTS  = 2,
  parameter int unsigned W_ADDR   = 32,
  parameter int unsigned W_DATA   = 32,
  parameter int unsigned ARB_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic [N_PORTS*2-1:0]        src_htrans,
  input  logic [N_PORTS*W_ADDR-1:0]   src_haddr,
  input  logic [N_PORTS*3-1:0]        src_hsize,
  input  logic [N_PORTS-1:0]          src_hwrite,
  input  logic [N_PORTS*4-1:0]        src_hprot,
  input  logic [N_PORTS*W_DATA-1:0]   src_hwdata,
  output logic [N_PORTS-1:0]          src_hready_resp,
  output logic [N_PORTS-1:0]          src_hresp,
  output logic [W_DATA-1:0]           src_hrdata,

  output logic [1:0]                  m_htrans,
  output logic [W_ADDR-1:0]           m_haddr,
  output logic [2:0]                  m_hsize,
  output logic                        m_hwrite,
  output logic [3:0]                  m_hprot,
  output logic [2:0]                  m_hburst,
  output logic                        m_hmastlock,
  output logic [W_DATA-1:0]           m_hwdata,
  input  logic                        m_hready,
  input  logic                        m_hresp,
  input  logic [W_DATA-1:0]           m_hrdata
);

  localparam int unsigned W_IDX = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic        RR_EN = (ARB_MODE == ARB_RR);

  // Buffered address phases, packed per port like the upstream buses.
  logic [N_PORTS-1:0]        buf_vld_q,   buf_vld_d;
  logic [N_PORTS*W_ADDR-1:0] buf_addr_q,  buf_addr_d;
  logic [N_PORTS*3-1:0]      buf_size_q,  buf_size_d;
  logic [N_PORTS-1:0]        buf_write_q, buf_write_d;
  logic [N_PORTS*4-1:0]      buf_prot_q,  buf_prot_d;

  logic                      dph_vld_q,    dph_vld_d;
  logic [W_IDX-1:0]          dph_owner_q,  dph_owner_d;
  logic                      hold_q,       hold_d;
  logic [W_IDX-1:0]          hold_owner_q, hold_owner_d;
  logic [W_IDX-1:0]          rr_ptr_q,     rr_ptr_d;

  logic [N_PORTS-1:0]        hready_int;
  logic [N_PORTS-1:0]        hresp_int;
  logic [N_PORTS-1:0]        live;
  logic [N_PORTS-1:0]        req;
  logic [N_PORTS-1:0]        pick_oh;
  logic [W_IDX-1:0]          pick_idx;
  logic                      gnt_vld;
  logic [W_IDX-1:0]          gnt_idx;
  logic                      taken;
  logic                      unused_htrans_lsb;

  // Upstream handshake: depends only on registered state and m_hready, never on the
  // grant, so there is no combinational loop through the arbiter.
  always_comb begin
    hready_int        = '1;
    hresp_int         = '0;
    live              = '0;
    unused_htrans_lsb = 1'b0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      if (buf_vld_q[i]) begin
        hready_int[i] = 1'b0;
      end else if (dph_vld_q && (dph_owner_q == W_IDX'(i))) begin
        hready_int[i] = m_hready;
      end
      hresp_int[i]      = dph_vld_q && (dph_owner_q == W_IDX'(i)) && m_hresp;
      live[i]           = src_htrans[2*i+1] && hready_int[i];
      unused_htrans_lsb = unused_htrans_lsb ^ src_htrans[2*i];
    end
  end

  assign src_hready_resp = hready_int;
  assign src_hresp       = hresp_int;
  assign src_hrdata      = m_hrdata;
  assign req             = buf_vld_q | live;

  hazard3_arb_rr #(
    .N_REQ (N_PORTS),
    .W_PTR (W_IDX)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .rr_en_i (RR_EN),
    .gnt_o   (pick_oh)
  );

  // Grant: a stalled downstream address phase pins the grant to its owner.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      if (pick_oh[i]) begin
        pick_idx = pick_idx | W_IDX'(i);
      end
    end
    gnt_vld = hold_q || (|req);
    gnt_idx = hold_q ? hold_owner_q : pick_idx;
    taken   = gnt_vld && m_hready;
  end

  // Downstream address mux: buffered phase wins over the live bus of the same port.
  always_comb begin
    m_htrans = HTRANS_IDLE;
    m_haddr  = '0;
    m_hsize  = '0;
    m_hwrite = 1'b0;
    m_hprot  = '0;
    if (gnt_vld) begin
      m_htrans = HTRANS_NSEQ;
      for (int i = 0; i < int'(N_PORTS); i++) begin
        if (gnt_idx == W_IDX'(i)) begin
          if (buf_vld_q[i]) begin
            m_haddr  = buf_addr_q[i*W_ADDR +: W_ADDR];
            m_hsize  = buf_size_q[i*3 +: 3];
            m_hwrite = buf_write_q[i];
            m_hprot  = buf_prot_q[i*4 +: 4];
          end else begin
            m_haddr  = src_haddr[i*W_ADDR +: W_ADDR];
            m_hsize  = src_hsize[i*3 +: 3];
            m_hwrite = src_hwrite[i];
            m_hprot  = src_hprot[i*4 +: 4];
          end
        end
      end
    end
  end

  assign m_hburst    = HBURST_SINGLE;
  assign m_hmastlock = 1'b0;

  // Write data follows the data-phase owner.
  always_comb begin
    m_hwdata = '0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      if (dph_owner_q == W_IDX'(i)) begin
        m_hwdata = src_hwdata[i*W_DATA +: W_DATA];
      end
    end
  end

  // Next state: buffer capture/release, data-phase tracking, hold and rotation pointer.
  always_comb begin
    buf_vld_d    = buf_vld_q;
    buf_addr_d   = buf_addr_q;
    buf_size_d   = buf_size_q;
    buf_write_d  = buf_write_q;
    buf_prot_d   = buf_prot_q;
    dph_vld_d    = dph_vld_q;
    dph_owner_d  = dph_owner_q;
    rr_ptr_d     = rr_ptr_q;
    hold_d       = gnt_vld && !m_hready;
    hold_owner_d = gnt_idx;

    for (int i = 0; i < int'(N_PORTS); i++) begin
      if (taken && (gnt_idx == W_IDX'(i))) begin
        buf_vld_d[i] = 1'b0;
      end else if (live[i]) begin
        // Includes the granted port stalled by m_hready: it replays from here unchanged.
        buf_vld_d[i]                  = 1'b1;
        buf_addr_d[i*W_ADDR +: W_ADDR] = src_haddr[i*W_ADDR +: W_ADDR];
        buf_size_d[i*3 +: 3]          = src_hsize[i*3 +: 3];
        buf_write_d[i]                = src_hwrite[i];
        buf_prot_d[i*4 +: 4]          = src_hprot[i*4 +: 4];
      end
    end

    if (m_hready) begin
      dph_vld_d = gnt_vld;
      if (gnt_vld) begin
        dph_owner_d = gnt_idx;
      end
    end

    if (RR_EN && taken) begin
      rr_ptr_d = (gnt_idx == W_IDX'(N_PORTS - 1)) ? '0 : gnt_idx + W_IDX'(1);
    end
  end

  // State registers; reset abandons any outstanding transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_vld_q    <= '0;
      buf_addr_q   <= '0;
      buf_size_q   <= '0;
      buf_write_q  <= '0;
      buf_prot_q   <= '0;
      dph_vld_q    <= 1'b0;
      dph_owner_q  <= '0;
      hold_q       <= 1'b0;
      hold_owner_q <= '0;
      rr_ptr_q     <= '0;
    end else begin
      buf_vld_q    <= buf_vld_d;
      buf_addr_q   <= buf_addr_d;
      buf_size_q   <= buf_size_d;
      buf_write_q  <= buf_write_d;
      buf_prot_q   <= buf_prot_d;
      dph_vld_q    <= dph_vld_d;
      dph_owner_q  <= dph_owner_d;
      hold_q       <= hold_d;
      hold_owner_q <= hold_owner_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

endmodule
